// File: rtl/tmr_voted_state_reg.sv
// ---------------------------------------------------------------------------
// tmr_voted_state_reg
//
// Purpose:
//   Hardened WIDTH-bit state register.
//   - The state is held in three redundant copies.
//   - The bitwise majority vote of the copies is presented on out_data.
//   - Every copy reloads from a single next value that is derived from the
//     vote. As a result, a single-copy upset is scrubbed on the next rising
//     edge regardless of en/mode.
//   - Disagreement between the copies is reported in two ways: a one-cycle
//     registered pulse, and a saturating mismatch counter.
//
// Parameters:
//   WIDTH      state / data width in bits (>= 1)
//   ERR_CNT_W  width of the saturating mismatch counter (>= 1)
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   en         in   1          update enable (low: hold, scrub only)
//   mode       in   1          0 = toggle (state ^= in_data), 1 = load
//   in_data    in   WIDTH      toggle mask or load value
//   err_clr    in   1          synchronous clear of err_cnt (wins over +1)
//   out_data   out  WIDTH      voted state (combinational from the copies)
//   err_pulse  out  1          copies disagreed during the previous cycle
//   err_cnt    out  ERR_CNT_W  saturating count of mismatch cycles
//
// Optional build macro TMR_FAULT_INJECT_EN adds:
//   inj_en     in   1          inject at this edge
//   inj_sel    in   2          copy to corrupt (0=a, 1=b, 2=c, 3=none)
//   inj_mask   in   WIDTH      XOR mask applied to the selected copy
// Without the macro these ports do not exist and all copies load next.
// ---------------------------------------------------------------------------
module tmr_voted_state_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 err_clr,
`ifdef TMR_FAULT_INJECT_EN
    input  logic                 inj_en,
    input  logic [1:0]           inj_sel,
    input  logic [WIDTH-1:0]     inj_mask,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Redundant state copies
    logic [WIDTH-1:0]     r_state_a;
    logic [WIDTH-1:0]     r_state_b;
    logic [WIDTH-1:0]     r_state_c;

    // Error reporting registers
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Combinational nets
    logic [WIDTH-1:0]     w_voted;
    logic [WIDTH-1:0]     w_next;
    logic [WIDTH-1:0]     w_next_a;
    logic [WIDTH-1:0]     w_next_b;
    logic [WIDTH-1:0]     w_next_c;
    logic                 w_mismatch;
    logic                 w_cnt_sat;

    // Bitwise two-out-of-three majority
    assign w_voted = (r_state_a & r_state_b) |
                     (r_state_a & r_state_c) |
                     (r_state_b & r_state_c);

    // Any bit where any copy differs from copy a means the copies are not
    // all equal (a^b and a^c together cover the b^c case).
    assign w_mismatch = |((r_state_a ^ r_state_b) | (r_state_a ^ r_state_c));

    assign w_cnt_sat = (r_err_cnt == '1);

    // The next value is derived only from the vote, never from an
    // individual copy. This is what makes the register self-scrubbing.
    always_comb begin
        w_next = w_voted;
        if (en) begin
            if (mode) begin
                w_next = in_data;
            end else begin
                w_next = w_voted ^ in_data;
            end
        end
    end

    // Per-copy load values. All copies are identical unless a fault is
    // deliberately injected into one of them.
    always_comb begin
        w_next_a = w_next;
        w_next_b = w_next;
        w_next_c = w_next;
`ifdef TMR_FAULT_INJECT_EN
        if (inj_en) begin
            case (inj_sel)
                2'd0:    w_next_a = w_next ^ inj_mask;
                2'd1:    w_next_b = w_next ^ inj_mask;
                2'd2:    w_next_c = w_next ^ inj_mask;
                default: ; // inj_sel = 3: inject nothing
            endcase
        end
`endif
    end

    // State copies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_a <= '0;
            r_state_b <= '0;
            r_state_c <= '0;
        end else begin
            r_state_a <= w_next_a;
            r_state_b <= w_next_b;
            r_state_c <= w_next_c;
        end
    end

    // Error pulse and saturating counter. err_clr affects only the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_mismatch && !w_cnt_sat) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign out_data  = w_voted;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tmr_voted_state_reg.sv
// ---------------------------------------------------------------------------
// tb_tmr_voted_state_reg
//
// Purpose:
//   Self-checking bench for tmr_voted_state_reg. Two instances are driven
//   from the same inputs:
//   - dut: default parameters.
//   - dut_s: ERR_CNT_W = 2, to exercise counter saturation.
//
//   Expected values come from a cycle-level model kept in this bench. The
//   model holds one architectural state value, a flag recording whether
//   one copy is currently corrupted, and the pulse and counter values.
//
//   Upsets are introduced as follows:
//   - With TMR_FAULT_INJECT_EN defined: through the inj_* ports.
//   - Otherwise: by briefly forcing one copy between clock edges.
// ---------------------------------------------------------------------------
module tb_tmr_voted_state_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] in_data;
    logic       err_clr;
    logic [7:0] out_data;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] out_data_s;
    logic       err_pulse_s;
    logic [1:0] err_cnt_s;
`ifdef TMR_FAULT_INJECT_EN
    logic       inj_en;
    logic [1:0] inj_sel;
    logic [7:0] inj_mask;
`endif

    // Reference model state
    logic [7:0] m_state;
    logic       m_corrupt;
    logic       m_pulse;
    int         m_cnt;
    int         m_cnt_s;

    // Force value (must be static for use in force)
    logic [7:0] fv;

    int checks;
    int failures;

    tmr_voted_state_reg #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_data(in_data),
        .err_clr(err_clr),
`ifdef TMR_FAULT_INJECT_EN
        .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
`endif
        .out_data(out_data), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    tmr_voted_state_reg #(.WIDTH(8), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_data(in_data),
        .err_clr(err_clr),
`ifdef TMR_FAULT_INJECT_EN
        .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
`endif
        .out_data(out_data_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = 8'h00;
        m_corrupt = 1'b0;
        m_pulse   = 1'b0;
        m_cnt     = 0;
        m_cnt_s   = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_out"},     {24'h0, out_data},   {24'h0, m_state});
        check_eq({tag, "_out_s"},   {24'h0, out_data_s}, {24'h0, m_state});
        check_eq({tag, "_pulse"},   {31'h0, err_pulse},  {31'h0, m_pulse});
        check_eq({tag, "_pulse_s"}, {31'h0, err_pulse_s}, {31'h0, m_pulse});
        check_eq({tag, "_cnt"},     {24'h0, err_cnt},    m_cnt);
        check_eq({tag, "_cnt_s"},   {30'h0, err_cnt_s},  m_cnt_s);
        if (!m_corrupt) begin
            check_eq({tag, "_copies"},
                     {8'h0, dut.r_state_a, dut.r_state_b, dut.r_state_c},
                     {8'h0, m_state, m_state, m_state});
        end
    endtask

    // One clock: the model is advanced from the inputs present at the edge,
    // then the outputs are sampled 1 time unit after the edge.
    task automatic step(input string tag);
        logic       mm;
        logic [7:0] nxt;
        mm = m_corrupt;
        if (!en)       nxt = m_state;
        else if (mode) nxt = in_data;
        else           nxt = m_state ^ in_data;
        m_pulse = mm;
        if (err_clr) begin
            m_cnt   = 0;
            m_cnt_s = 0;
        end else if (mm) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
`ifdef TMR_FAULT_INJECT_EN
        m_corrupt = inj_en && (inj_sel != 2'd3) && (inj_mask != 8'h00);
`else
        m_corrupt = 1'b0;
`endif
        m_state = nxt;
        @(posedge clk);
        #1;
`ifdef TMR_FAULT_INJECT_EN
        inj_en = 1'b0;
`endif
        check_all(tag);
    endtask

    // Corrupt a single copy in both instances.
    task automatic upset(input logic [1:0] sel, input logic [7:0] mask);
`ifdef TMR_FAULT_INJECT_EN
        inj_en   = 1'b1;
        inj_sel  = sel;
        inj_mask = mask;
`else
        fv = m_state ^ mask;
        case (sel)
            2'd0: begin force dut.r_state_a = fv; force dut_s.r_state_a = fv; end
            2'd1: begin force dut.r_state_b = fv; force dut_s.r_state_b = fv; end
            2'd2: begin force dut.r_state_c = fv; force dut_s.r_state_c = fv; end
            default: ;
        endcase
        #1;
        case (sel)
            2'd0: begin release dut.r_state_a; release dut_s.r_state_a; end
            2'd1: begin release dut.r_state_b; release dut_s.r_state_b; end
            2'd2: begin release dut.r_state_c; release dut_s.r_state_c; end
            default: ;
        endcase
        m_corrupt = (sel != 2'd3) && (mask != 8'h00);
        // A single bad copy must not disturb the vote.
        check_eq("upset_vote", {24'h0, out_data}, {24'h0, m_state});
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        en       = 1'b0;
        mode     = 1'b0;
        in_data  = 8'h00;
        err_clr  = 1'b0;
`ifdef TMR_FAULT_INJECT_EN
        inj_en   = 1'b0;
        inj_sel  = 2'd0;
        inj_mask = 8'h00;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Build up state 0xA5 with a nonzero error count, then reset mid-cycle
        en = 1'b1; mode = 1'b1; in_data = 8'hA5;
        step("pre_load");
        en = 1'b0;
        upset(2'd1, 8'h01);
        step("pre_up1");
        step("pre_up2");
        check_eq("pre_cnt_nonzero", {31'h0, (err_cnt != 8'h00)}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Load then toggle then hold
        en = 1'b1; mode = 1'b1; in_data = 8'h3C;
        step("load_3c");
        check_eq("load_3c_abs", {24'h0, out_data}, 32'h3C);
        mode = 1'b0; in_data = 8'hFF;
        step("toggle_ff");
        check_eq("toggle_abs", {24'h0, out_data}, 32'hC3);
        en = 1'b0;
        repeat (5) step("hold");
        check_eq("hold_abs", {24'h0, out_data}, 32'hC3);

        // Single-copy upset on copy b while holding
        upset(2'd1, 8'h01);
        step("upset_b1");
        step("upset_b2");
        step("upset_b3");
        check_eq("upset_cnt_abs", {24'h0, err_cnt}, 32'h1);

        // err_clr coinciding with mismatch
        upset(2'd2, 8'h10);
        err_clr = 1'b1;
        step("clr1");
        step("clr2");
        err_clr = 1'b0;
        check_eq("clr_cnt_abs", {24'h0, err_cnt}, 32'h0);
        step("clr3");

        // Saturation of the narrow counter: upsets on consecutive cycles
        err_clr = 1'b1;
        step("sat_clr");
        err_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            upset(2'(k % 3), 8'(1 << k));
            step("sat");
        end
        step("sat_tail1");
        step("sat_tail2");
        check_eq("sat_abs", {30'h0, err_cnt_s}, 32'h3);

`ifdef TMR_FAULT_INJECT_EN
        // inj_sel = 3 injects nothing
        inj_en = 1'b1; inj_sel = 2'd3; inj_mask = 8'hFF;
        step("inj_off1");
        step("inj_off2");
`endif

        // Randomized operation with occasional upsets and clears
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            mode    = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                upset(2'($urandom_range(0, 2)), 8'($urandom_range(1, 255)));
            step("rand");
            if (i % 100 == 99) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rand_rst");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
